// File: rtl/regfile_sb.sv
// regfile_sb: multi-ported register file with per-register pending-write scoreboard
module regfile_sb #(
  parameter int WIDTH  = 32,
  parameter int ADDRW  = 5,
  parameter int CNTW   = 2,
  parameter int BYPASS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ADDRW-1:0] ra1,
  input  logic [ADDRW-1:0] ra2,
  input  logic             ren1,
  input  logic             ren2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic             busy1,
  output logic             busy2,
  output logic             stall,
  input  logic             we3,
  input  logic [ADDRW-1:0] wa3,
  input  logic [WIDTH-1:0] wd3,
  input  logic             iss,
  input  logic [ADDRW-1:0] iwa,
  output logic             iss_full
);
  localparam int DEPTH = 2 ** ADDRW;
  logic [WIDTH-1:0] regs [DEPTH];
  logic [CNTW-1:0]  cnt  [DEPTH];
  logic [DEPTH-1:0] inc_v, dec_v;
  logic             fwd1, fwd2;
  always_comb begin
    fwd1     = BYPASS != 0 && we3 && wa3 == ra1;
    fwd2     = BYPASS != 0 && we3 && wa3 == ra2;
    rd1      = ra1 == '0 ? '0 : fwd1 ? wd3 : regs[ra1];
    rd2      = ra2 == '0 ? '0 : fwd2 ? wd3 : regs[ra2];
    busy1    = ra1 != '0 && cnt[ra1] != '0 && !(fwd1 && cnt[ra1] == CNTW'(1));
    busy2    = ra2 != '0 && cnt[ra2] != '0 && !(fwd2 && cnt[ra2] == CNTW'(1));
    stall    = (ren1 & busy1) | (ren2 & busy2);
    iss_full = iwa != '0 && cnt[iwa] == '1;
    inc_v    = iss && !iss_full ? DEPTH'(1) << iwa : '0;
    dec_v    = we3 ? DEPTH'(1) << wa3 : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
    end else begin
      if (we3 && wa3 != '0) regs[wa3] <= wd3;
      // register 0 is skipped so its counter stays at its reset value
      for (int r = 1; r < DEPTH; r++)
        cnt[r] <= inc_v[r] && !dec_v[r] ? cnt[r] + CNTW'(1) :
                  !inc_v[r] && dec_v[r] && cnt[r] != '0 ? cnt[r] - CNTW'(1) : cnt[r];
    end
  end
endmodule
